// File: rtl/topk_collector.sv
// ---------------------------------------------------------------------------
// topk_collector
//
// Keeps the K largest unsigned elements seen across a query. A query is a
// stream of blocks from the 8-input bitonic sorter; each block arrives already
// sorted in descending order. When the last block has been folded in, the
// result is streamed out one element per handshake, largest first.
//
// Optional feature (build macro):
//   TOPK_COLLECTOR_STATS_EN - adds blk_cnt_o, a saturating 16-bit count of
//                             the blocks accepted in the current query.
//
// Parameters:
//   DATAWIDTH   - unsigned element width
//   K           - block length and result depth (only 8 is supported; the
//                 merge network below is built for exactly 8 lanes)
//
// Ports:
//   clk_i        in   single clock
//   rstn_i       in   synchronous active-low reset
//   blk_valid_i  in   sorted block present this cycle (no backpressure)
//   blk_last_i   in   current block is the final block of the query
//   blk_i        in   K x DATAWIDTH sorted block, index 0 largest
//   busy_o       out  high while draining the result
//   drop_o       out  one-cycle pulse after a block was discarded
//   ovf_o        out  sticky "a block was discarded", cleared only by reset
//   res_valid_o  out  result element valid
//   res_ready_i  in   consumer accepts the result element
//   res_data_o   out  result element
//   res_idx_o    out  rank of res_data_o, 0 is largest
//   res_last_o   out  high with rank K-1
//   blk_cnt_o    out  (TOPK_COLLECTOR_STATS_EN only) accepted block count
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no query open; first valid block is loaded straight into top
// ACCUM  | query open; each valid block is merged into top in one cycle
// DRAIN  | result streamed out by idx; incoming blocks are dropped
// ---------------------------------------------------------------------------
module topk_collector #(
    parameter int DATAWIDTH = 8,
    parameter int K         = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 blk_valid_i,
    input  logic                 blk_last_i,
    input  logic [DATAWIDTH-1:0] blk_i [K],
    output logic                 busy_o,
    output logic                 drop_o,
    output logic                 ovf_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [DATAWIDTH-1:0] res_data_o,
    output logic [2:0]           res_idx_o,
    output logic                 res_last_o
`ifdef TOPK_COLLECTOR_STATS_EN
    ,
    output logic [15:0]          blk_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATAWIDTH-1:0] top    [K];
    logic [DATAWIDTH-1:0] c0     [K];
    logic [DATAWIDTH-1:0] c1     [K];
    logic [DATAWIDTH-1:0] c2     [K];
    logic [DATAWIDTH-1:0] merged [K];

    logic [2:0] idx;
    logic       load_top;
    logic       merge_top;
    logic       drop_cond;
    logic       res_hs;
    logic       drain_done;

    function automatic logic [DATAWIDTH-1:0] max_f(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic logic [DATAWIDTH-1:0] min_f(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
        return (a >= b) ? b : a;
    endfunction

    // -----------------------------------------------------------------------
    // Merge network. top is descending and the reversed block is ascending,
    // so the lane-wise max c0 is a bitonic sequence holding the K largest of
    // the union. Three half-cleaner stages (distance 4, 2, 1) sort it
    // descending. Ties keep either copy, so duplicates survive.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < K; i++) begin
            c0[i] = max_f(top[i], blk_i[K-1-i]);
        end

        for (int i = 0; i < K/2; i++) begin
            c1[i]       = max_f(c0[i], c0[i+K/2]);
            c1[i+K/2]   = min_f(c0[i], c0[i+K/2]);
        end

        for (int h = 0; h < K; h += K/2) begin
            for (int i = 0; i < K/4; i++) begin
                c2[h+i]       = max_f(c1[h+i], c1[h+i+K/4]);
                c2[h+i+K/4]   = min_f(c1[h+i], c1[h+i+K/4]);
            end
        end

        for (int i = 0; i < K; i += 2) begin
            merged[i]   = max_f(c2[i], c2[i+1]);
            merged[i+1] = min_f(c2[i], c2[i+1]);
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_top    = 1'b0;
        merge_top   = 1'b0;
        drop_cond   = 1'b0;
        res_hs      = 1'b0;
        drain_done  = 1'b0;
        busy_o      = 1'b0;
        res_valid_o = 1'b0;
        res_last_o  = 1'b0;
        res_idx_o   = '0;
        res_data_o  = '0;

        case (state)
            IDLE: begin
                if (blk_valid_i) begin
                    load_top  = 1'b1;
                    state_nxt = blk_last_i ? DRAIN : ACCUM;
                end
            end

            ACCUM: begin
                if (blk_valid_i) begin
                    merge_top = 1'b1;
                    if (blk_last_i) begin
                        state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                res_idx_o   = idx;
                res_data_o  = top[idx];
                res_last_o  = (idx == 3'(K-1));
                drop_cond   = blk_valid_i;
                res_hs      = res_ready_i;
                if (res_ready_i && (idx == 3'(K-1))) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: top register, drain index, drop/overflow flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < K; i++) begin
                top[i] <= '0;
            end
            idx    <= '0;
            drop_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            drop_o <= drop_cond;
            if (drop_cond) begin
                ovf_o <= 1'b1;
            end

            if (load_top) begin
                for (int i = 0; i < K; i++) begin
                    top[i] <= blk_i[i];
                end
            end else if (merge_top) begin
                for (int i = 0; i < K; i++) begin
                    top[i] <= merged[i];
                end
            end

            // Held at zero outside DRAIN so every drain starts at rank 0.
            if (state != DRAIN) begin
                idx <= '0;
            end else if (res_hs) begin
                idx <= idx + 3'd1;
            end
        end
    end

`ifdef TOPK_COLLECTOR_STATS_EN
    logic blk_accept;

    assign blk_accept = load_top | merge_top;

    // Blocks dropped in DRAIN never assert load_top/merge_top, so they are
    // not counted. The count stays visible through DRAIN and clears as the
    // FSM returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            blk_cnt_o <= '0;
        end else if (drain_done) begin
            blk_cnt_o <= '0;
        end else if (blk_accept && (blk_cnt_o != 16'hFFFF)) begin
            blk_cnt_o <= blk_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_topk_collector.sv
module tb_topk_collector;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       blk_valid_i;
    logic       blk_last_i;
    logic [7:0] blk_i [8];
    logic       busy_o;
    logic       drop_o;
    logic       ovf_o;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_data_o;
    logic [2:0] res_idx_o;
    logic       res_last_o;
`ifdef TOPK_COLLECTOR_STATS_EN
    logic [15:0] blk_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    topk_collector #(.DATAWIDTH(8), .K(8)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .blk_valid_i (blk_valid_i),
        .blk_last_i  (blk_last_i),
        .blk_i       (blk_i),
        .busy_o      (busy_o),
        .drop_o      (drop_o),
        .ovf_o       (ovf_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_idx_o   (res_idx_o),
        .res_last_o  (res_last_o)
`ifdef TOPK_COLLECTOR_STATS_EN
        ,
        .blk_cnt_o   (blk_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Blocks and results are written as packed words, byte 0 (rank 0) in the
    // most significant position so the literals read largest-first.
    function automatic logic [7:0] byte_at(input logic [63:0] w, input int k);
        return w[63-8*k -: 8];
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_blk(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            blk_i[i] = byte_at(w, i);
        end
    endtask

    task automatic send(input logic [63:0] w, input logic last);
        set_blk(w);
        blk_valid_i = 1'b1;
        blk_last_i  = last;
        tick();
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
    endtask

    // Drain with res_ready_i held high, checking each beat and the return to IDLE.
    task automatic drain_check(input string tag, input logic [63:0] exp);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 32'(res_valid_o), 32'd1);
            check($sformatf("%s_data%0d", tag, k), 32'(res_data_o), 32'(byte_at(exp, k)));
            check($sformatf("%s_idx%0d", tag, k), 32'(res_idx_o), 32'(k));
            check($sformatf("%s_last%0d", tag, k), 32'(res_last_o), 32'(k == 7));
            tick();
        end
        check($sformatf("%s_end_valid", tag), 32'(res_valid_o), 32'd0);
        check($sformatf("%s_end_busy", tag), 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [3:0] bp_pat;
        int         exp_idx;
        int         cyc;

        rstn_i      = 1'b0;
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
        res_ready_i = 1'b0;
        set_blk(64'h0);
        tick(); tick(); tick();

        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_drop",  32'(drop_o),      32'd0);
        check("rst_ovf",   32'(ovf_o),       32'd0);
        check("rst_idx",   32'(res_idx_o),   32'd0);
        check("rst_last",  32'(res_last_o),  32'd0);
        rstn_i = 1'b1;
        tick();

        // Single block
        res_ready_i = 1'b1;
        send(64'h09_07_05_04_03_02_01_00, 1'b1);
        check("single_busy", 32'(busy_o), 32'd1);
        drain_check("single", 64'h09_07_05_04_03_02_01_00);

        // Two blocks with an idle gap carrying a stray last (ignored without valid)
        send(64'h08_06_04_02_00_00_00_00, 1'b0);
        blk_last_i = 1'b1;
        tick();
        blk_last_i = 1'b0;
        check("two_gap_busy", 32'(busy_o), 32'd0);
        check("two_gap_valid", 32'(res_valid_o), 32'd0);
        send(64'h07_05_03_01_01_01_01_01, 1'b1);
        drain_check("two", 64'h08_07_06_05_04_03_02_01);

        // Three blocks, values above 127 to exercise unsigned compare
        send(64'hC8_64_32_0A_09_08_07_06, 1'b0);
        send(64'hFF_96_78_64_03_02_01_00, 1'b0);
        send(64'h63_62_61_60_5F_5E_5D_5C, 1'b1);
`ifdef TOPK_COLLECTOR_STATS_EN
        check("three_cnt", 32'(blk_cnt_o), 32'd3);
`endif
        drain_check("three", 64'hFF_C8_96_78_64_64_63_62);

        // Duplicates retained
        send(64'h05_05_05_05_05_05_05_05, 1'b0);
        send(64'h05_05_05_05_04_04_04_04, 1'b1);
        drain_check("dup", 64'h05_05_05_05_05_05_05_05);

        // Backpressure: ready pattern 1,0,0,1 repeating
        send(64'h09_07_05_04_03_02_01_00, 1'b1);
        bp_pat  = 4'b1001;
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < 8 && cyc < 40) begin
            check($sformatf("bp_valid_c%0d", cyc), 32'(res_valid_o), 32'd1);
            check($sformatf("bp_data_c%0d", cyc), 32'(res_data_o),
                  32'(byte_at(64'h09_07_05_04_03_02_01_00, exp_idx)));
            check($sformatf("bp_idx_c%0d", cyc), 32'(res_idx_o), 32'(exp_idx));
            res_ready_i = bp_pat[3 - (cyc % 4)];
            tick();
            if (res_ready_i) exp_idx++;
            cyc++;
        end
        check("bp_beats", 32'(exp_idx), 32'd8);
        check("bp_end_valid", 32'(res_valid_o), 32'd0);
        res_ready_i = 1'b1;

        // Overflow: blocks during drain (beat 2 and the final handshake) are dropped
        send(64'h30_20_10_08_04_02_01_00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf_data%0d", k), 32'(res_data_o),
                  32'(byte_at(64'h30_20_10_08_04_02_01_00, k)));
            check($sformatf("ovf_idx%0d", k), 32'(res_idx_o), 32'(k));
            if (k == 3) begin
                check("ovf_drop_pulse", 32'(drop_o), 32'd1);
                check("ovf_sticky_set", 32'(ovf_o),  32'd1);
            end
            if (k == 4) begin
                check("ovf_drop_clear", 32'(drop_o), 32'd0);
                check("ovf_sticky_hold", 32'(ovf_o), 32'd1);
            end
            set_blk(64'hFF_FF_FF_FF_FF_FF_FF_FF);
            blk_valid_i = (k == 2) || (k == 7);
            blk_last_i  = 1'b1;
            tick();
        end
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
        check("ovf_final_drop", 32'(drop_o), 32'd1);
        check("ovf_final_valid", 32'(res_valid_o), 32'd0);
        check("ovf_final_busy", 32'(busy_o), 32'd0);
        tick();
        check("ovf_after_drop", 32'(drop_o), 32'd0);
        check("ovf_after_busy", 32'(busy_o), 32'd0);
        check("ovf_after_valid", 32'(res_valid_o), 32'd0);
        check("ovf_after_sticky", 32'(ovf_o), 32'd1);

        // Reset mid-drain at beat 3
        send(64'h90_80_70_60_50_40_30_20, 1'b1);
        tick(); tick(); tick();
        check("rstmid_idx3", 32'(res_idx_o), 32'd3);
        check("rstmid_data3", 32'(res_data_o), 32'h60);
        rstn_i = 1'b0;
        tick();
        check("rstmid_valid", 32'(res_valid_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_idx", 32'(res_idx_o), 32'd0);
        check("rstmid_ovf", 32'(ovf_o), 32'd0);
        rstn_i = 1'b1;
        tick();
        check("rstmid_idle_valid", 32'(res_valid_o), 32'd0);
        send(64'h64_5A_50_46_3C_32_28_1E, 1'b1);
        drain_check("post_rst", 64'h64_5A_50_46_3C_32_28_1E);

`ifdef TOPK_COLLECTOR_STATS_EN
        // Saturating block counter
        set_blk(64'h01_01_01_01_01_01_01_01);
        blk_valid_i = 1'b1;
        blk_last_i  = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk_i);
        end
        #1;
        blk_last_i = 1'b1;
        tick();
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
        check("stats_sat", 32'(blk_cnt_o), 32'h0000FFFF);
        drain_check("stats", 64'h01_01_01_01_01_01_01_01);
        check("stats_clear", 32'(blk_cnt_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
